// File: rtl/modn_sched_pkg.sv
// rtl/modn_sched_pkg.sv - shared state type and one-hot helper for the mod-N timer scheduler
package modn_sched_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sched_state_t;

   localparam int MAX_REQ = 32;

   function automatic logic [MAX_REQ-1:0] onehot(input int unsigned idx);
      logic [MAX_REQ-1:0] v;
      v = '0;
      v[idx[4:0]] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/modn_load_ctr.sv
// rtl/modn_load_ctr.sv - shared runtime-modulus counter, wraps to 0 on terminal count
module modn_load_ctr #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             clr,
   input  logic             en,
   input  logic [WIDTH-1:0] len,
   output logic [WIDTH-1:0] out,
   output logic             tc
);

   // len of 0 wraps to all-ones, giving a full 2^WIDTH period
   assign tc = en && (out == (len - WIDTH'(1)));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out <= '0;
      end else if (clr) begin
         out <= '0;
      end else if (en) begin
         out <= tc ? '0 : out + WIDTH'(1);
      end
   end

endmodule

// File: rtl/modn_timer_sched.sv
// rtl/modn_timer_sched.sv - round-robin arbiter sharing one mod-N counter among NREQ requesters
module modn_timer_sched
   import modn_sched_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int NREQ  = 4
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] req_len,
   output logic [NREQ-1:0]       gnt,
   output logic [NREQ-1:0]       done,
   output logic                  busy,
   output logic [WIDTH-1:0]      cnt
);

   localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

   sched_state_t    state, state_nx;
   logic [IDXW-1:0] last, sel;
   logic            found;
   logic [WIDTH-1:0] len_q;
   logic [NREQ-1:0] gnt_nx, done_nx;
   logic            owner_req, ctr_clr, ctr_en, ctr_tc;

   // Search starts just above the last winner so every requester gets a turn
   always_comb begin
      sel   = last;
      found = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         if (!found && req[(int'(last) + k) % NREQ]) begin
            sel   = IDXW'((int'(last) + k) % NREQ);
            found = 1'b1;
         end
      end
   end

   assign owner_req = |(req & gnt);
   assign ctr_en    = (state == RUN) && owner_req;

   always_comb begin
      state_nx = state;
      gnt_nx   = gnt;
      done_nx  = '0;
      ctr_clr  = 1'b0;
      case (state)
         IDLE: begin
            if (found) begin
               state_nx = RUN;
               gnt_nx   = NREQ'(onehot(int'(sel)));
               ctr_clr  = 1'b1;
            end
         end
         RUN: begin
            // A dropped request wins over a coincident terminal count
            if (!owner_req) begin
               state_nx = IDLE;
               gnt_nx   = '0;
               ctr_clr  = 1'b1;
            end else if (ctr_tc) begin
               state_nx = DONE;
               gnt_nx   = '0;
               done_nx  = gnt;
            end
         end
         DONE: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
            gnt_nx   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
         last  <= IDXW'(NREQ - 1);
         gnt   <= '0;
         done  <= '0;
         len_q <= '0;
      end else begin
         state <= state_nx;
         gnt   <= gnt_nx;
         done  <= done_nx;
         if (state == IDLE && found) begin
            last  <= sel;
            len_q <= req_len[int'(sel)*WIDTH +: WIDTH];
         end
      end
   end

   assign busy = (state == RUN);

   modn_load_ctr #(.WIDTH(WIDTH)) u_ctr (
      .clk  (clk),
      .rstn (rstn),
      .clr  (ctr_clr),
      .en   (ctr_en),
      .len  (len_q),
      .out  (cnt),
      .tc   (ctr_tc)
   );

endmodule

// File: tb/tb_modn_timer_sched.sv
// tb/tb_modn_timer_sched.sv - self-checking bench for modn_timer_sched
module tb_modn_timer_sched;

   localparam int WIDTH = 4;
   localparam int NREQ  = 4;

   logic                  clk = 1'b0;
   logic                  rstn = 1'b0;
   logic [NREQ-1:0]       req = '0;
   logic [NREQ*WIDTH-1:0] req_len = '0;
   logic [NREQ-1:0]       gnt, done;
   logic                  busy;
   logic [WIDTH-1:0]      cnt;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int done_who[$];
   int done_cyc[$];

   // Transaction view: owner, cycles of grant shown so far, service length
   int m_owner = -1;
   int m_age   = 0;
   int m_len   = 0;
   int m_last  = NREQ - 1;

   always #5 clk = ~clk;

   modn_timer_sched #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
      .clk     (clk),
      .rstn    (rstn),
      .req     (req),
      .req_len (req_len),
      .gnt     (gnt),
      .done    (done),
      .busy    (busy),
      .cnt     (cnt)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h at cycle %0d", name, got, exp, cyc);
      end
   endtask

   function automatic int len_of(input int i);
      int v;
      v = int'(req_len[i*WIDTH +: WIDTH]);
      return (v == 0) ? (1 << WIDTH) : v;
   endfunction

   function automatic int pick_next(input int from);
      for (int k = 1; k <= NREQ; k++) begin
         if (req[(from + k) % NREQ]) return (from + k) % NREQ;
      end
      return -1;
   endfunction

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_owner = -1;
         m_age   = 0;
         m_last  = NREQ - 1;
      end else if (m_owner < 0) begin
         m_owner = pick_next(m_last);
         if (m_owner >= 0) begin
            m_age  = 0;
            m_len  = len_of(m_owner);
            m_last = m_owner;
         end
      end else if (m_age < m_len) begin
         if (!req[m_owner]) m_owner = -1;
         else m_age++;
      end else begin
         m_owner = -1;
      end
   end

   always @(negedge clk) begin
      logic [NREQ-1:0] eg, ed;
      logic            eb;
      int              ec;
      cyc++;
      eg = '0; ed = '0; eb = 1'b0; ec = 0;
      if (m_owner >= 0 && m_age < m_len) begin
         eg = NREQ'(1 << m_owner);
         eb = 1'b1;
         ec = m_age;
      end else if (m_owner >= 0) begin
         ed = NREQ'(1 << m_owner);
      end
      check("model_gnt", gnt, eg);
      check("model_done", done, ed);
      check("model_busy", busy, eb);
      check("model_cnt", cnt, ec);
      if (done != 0) begin
         done_who.push_back(int'(done));
         done_cyc.push_back(cyc);
      end
   end

   task automatic nx();
      @(negedge clk);
   endtask

   task automatic set_len(input int i, input int v);
      req_len[i*WIDTH +: WIDTH] = WIDTH'(v);
   endtask

   task automatic clear_log();
      done_who.delete();
      done_cyc.delete();
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      req  = '0;
      nx();
      rstn = 1'b1;
   endtask

   // Runs until every request has completed, dropping each bit on its done
   task automatic run_drop(input int maxc);
      int n;
      n = 0;
      while (req != 0 && n < maxc) begin
         nx();
         n++;
         if (done != 0) req = req & ~done;
      end
      check("run_timeout", {31'd0, req == 0}, 32'd1);
      nx();
   endtask

   task automatic wait_cnt(input int v, input int maxc);
      int n;
      n = 0;
      while (cnt != WIDTH'(v) && n < maxc) begin
         nx();
         n++;
      end
      check("wait_cnt_timeout", cnt, v);
   endtask

   initial begin
      nx();
      check("rst_gnt", gnt, 0);
      check("rst_done", done, 0);
      check("rst_busy", busy, 0);
      check("rst_cnt", cnt, 0);
      rstn = 1'b1;

      // single request, len 3
      set_len(0, 3);
      req = 4'b0001;
      for (int i = 0; i < 3; i++) begin
         nx();
         check("t1_gnt", gnt, 4'b0001);
         check("t1_cnt", cnt, i);
      end
      nx();
      check("t1_done", done, 4'b0001);
      check("t1_gnt_off", gnt, 0);
      req = '0;
      nx();
      check("t1_idle_done", done, 0);
      check("t1_idle_busy", busy, 0);

      // all four requesting, len 2 each
      do_reset();
      for (int i = 0; i < NREQ; i++) set_len(i, 2);
      clear_log();
      req = 4'b1111;
      run_drop(60);
      check("t2_count", done_who.size(), 4);
      if (done_who.size() == 4) begin
         check("t2_order0", done_who[0], 1);
         check("t2_order1", done_who[1], 2);
         check("t2_order2", done_who[2], 4);
         check("t2_order3", done_who[3], 8);
         for (int k = 0; k < 3; k++) check("t2_spacing", done_cyc[k+1] - done_cyc[k], 4);
      end

      // rotation: after serving 2, requester 0 wins ahead of 2
      req = 4'b0100;
      run_drop(20);
      clear_log();
      req = 4'b0101;
      run_drop(40);
      check("t3_count", done_who.size(), 2);
      if (done_who.size() == 2) begin
         check("t3_first", done_who[0], 1);
         check("t3_second", done_who[1], 4);
      end

      // len 0 means full 2^WIDTH period
      set_len(0, 0);
      req = 4'b0001;
      for (int i = 0; i < 16; i++) begin
         nx();
         check("t4_gnt", gnt, 4'b0001);
         check("t4_cnt", cnt, i);
      end
      nx();
      check("t4_done", done, 4'b0001);
      req = '0;
      nx();

      // abort at cnt 2
      set_len(1, 8);
      req = 4'b0010;
      wait_cnt(2, 20);
      req = '0;
      nx();
      check("t5_abort_gnt", gnt, 0);
      check("t5_abort_cnt", cnt, 0);
      check("t5_abort_done", done, 0);
      check("t5_abort_busy", busy, 0);
      nx();
      check("t5_no_done", done, 0);

      // req_len change mid-run is ignored
      set_len(1, 5);
      req = 4'b0010;
      nx();
      check("t5b_cnt0", cnt, 0);
      set_len(1, 2);
      for (int i = 1; i < 5; i++) begin
         nx();
         check("t5b_cnt", cnt, i);
      end
      nx();
      check("t5b_done", done, 4'b0010);
      req = '0;
      nx();

      // asynchronous reset mid-count
      set_len(0, 10);
      req = 4'b0001;
      wait_cnt(5, 20);
      #1 rstn = 1'b0;
      #1;
      check("t6_async_gnt", gnt, 0);
      check("t6_async_busy", busy, 0);
      check("t6_async_cnt", cnt, 0);
      check("t6_async_done", done, 0);
      nx();
      rstn = 1'b1;
      set_len(1, 2);
      set_len(3, 2);
      clear_log();
      req = 4'b1010;
      nx();
      check("t6_first_gnt", gnt, 4'b0010);
      run_drop(40);
      check("t6_count", done_who.size(), 2);
      if (done_who.size() == 2) begin
         check("t6_first", done_who[0], 2);
         check("t6_second", done_who[1], 8);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got running exp finished");
      $fatal(1, "timeout");
   end

endmodule
